wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline's
//  write-back result and a multi-cycle unit (MUL/load-miss) that returns GPR
//  results out of band. Pipeline writes have priority; long-unit results are
//  queued in a small FIFO and drained into idle write-back slots, with a
//  starvation guard that stalls the pipeline for one cycle. Sits between the WB
//  stage and the register file; also reports pending destinations to decode.
// PARAMETERS
//  DEPTH         4   long-unit result FIFO entries (power of two, >=2)
//  STARVE_LIMIT  8   cycles a non-empty FIFO may wait before StallPipe fires (>=2)
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  PipeRegWrite     in   1   WB stage requests a register write
//  PipeWriteAddr    in   5   WB stage destination register
//  PipeWriteData    in   32  WB stage write data
//  LongValid        in   1   long unit offers a result
//  LongReady        out  1   arbiter accepts the result this cycle
//  LongAddr         in   5   long unit destination register
//  LongData         in   32  long unit result
//  RegWriteOut      out  1   register-file write enable
//  WriteRegAddrOut  out  5   register-file write address
//  WriteRegData     out  32  register-file write data
//  StallPipe        out  1   registered; pipeline must hold its WB inputs
//  QueryAddrA/B     in   5   decode source/destination addresses to check
//  QueryHitA/B      out  1   a valid queued entry targets QueryAddrA/B
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO pointers/count=0, all entry valid bits=0,
//   starvation counter=0, StallPipe=0; RegWriteOut forced 0 while rst_n=0.
//  FIFO: entries {addr,data,valid}; pointers wrap modulo DEPTH; count 0..DEPTH.
//   LongReady = (count<DEPTH), independent of a same-cycle pop.
//   Push on LongValid&&LongReady; LongAddr==0 is accepted but not stored.
//  Port grant (combinational, same-cycle, zero latency to register file):
//   pipe_act = PipeRegWrite && PipeWriteAddr!=0.
//   1) StallPipe=1: FIFO head owns the port; pipeline inputs ignored.
//   2) else pipe_act: pipeline data drives the port.
//   3) else count>0: FIFO head drives the port and is popped.
//   4) else RegWriteOut=0 (address/data outputs don't-care, drive 0).
//   Head with valid=0 is popped with RegWriteOut=0 (consumes the slot).
//  Younger-wins: a granted pipeline write to address X clears valid on every
//   stored entry with addr X in the same edge (WAW protection).
//  Starvation: counter increments each cycle count>0 and no pop; clears on a
//   pop or when empty. When counter reaches STARVE_LIMIT-1 without a pop,
//   StallPipe=1 for exactly the next cycle, counter cleared; that cycle pops
//   the head (rule 1). If FIFO becomes empty anyway, stall cycle writes nothing.
//  QueryHitX = QueryAddrX!=0 && any stored valid entry addr==QueryAddrX;
//   same-cycle incoming push not included.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
// TESTING
//  1 Pipe only: PipeRegWrite=1, addr 5, data 0x11 -> RegWriteOut=1, addr 5, 0x11 same cycle.
//  2 Idle drain: push {7,0xAA},{8,0xBB} with pipe idle -> writes r7 then r8 on successive cycles, LongReady stays 1.
//  3 Full: DEPTH pushes with pipe busy every cycle -> LongReady=0 at count=4; QueryHitA=1 for addr 7.
//  4 Starvation: FIFO holds {9,0x55}, pipe writes r1 each cycle -> StallPipe=1 on cycle 8, r9 written that cycle.
//  5 WAW kill: FIFO holds {3,0x33}, pipe writes r3=0x44 -> entry drops, later slot writes nothing, r3 keeps 0x44.
//  6 Reset mid-queue: 3 entries queued, pulse rst_n low -> count=0, StallPipe=0, QueryHit=0, no stale write.

Source files
------------

// File: rtl/wb_port_if.sv
// Write-back port bundle between the WB stage / long unit (master side) and the
// register-file write-port arbiter (slave side).
interface wb_port_if;
    logic        PipeRegWrite;
    logic [4:0]  PipeWriteAddr;
    logic [31:0] PipeWriteData;
    logic        LongValid;
    logic        LongReady;
    logic [4:0]  LongAddr;
    logic [31:0] LongData;
    logic        RegWriteOut;
    logic [4:0]  WriteRegAddrOut;
    logic [31:0] WriteRegData;
    logic        StallPipe;
    logic [4:0]  QueryAddrA;
    logic [4:0]  QueryAddrB;
    logic        QueryHitA;
    logic        QueryHitB;

    modport master (
        output PipeRegWrite, PipeWriteAddr, PipeWriteData,
        output LongValid, LongAddr, LongData,
        output QueryAddrA, QueryAddrB,
        input  LongReady, RegWriteOut, WriteRegAddrOut, WriteRegData,
        input  StallPipe, QueryHitA, QueryHitB
    );

    modport slave (
        input  PipeRegWrite, PipeWriteAddr, PipeWriteData,
        input  LongValid, LongAddr, LongData,
        input  QueryAddrA, QueryAddrB,
        output LongReady, RegWriteOut, WriteRegAddrOut, WriteRegData,
        output StallPipe, QueryHitA, QueryHitB
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-unit
// results wait in a small FIFO and drain into idle slots, with a starvation stall.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_port_if.slave  bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;

    logic          long_ready, push, store, pipe_act, not_empty, head_valid;
    logic          pop, pipe_grant, wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          hit_a, hit_b;

    // Port grant, FIFO bookkeeping and starvation tracking
    always_comb begin
        pop        = 1'b0;
        pipe_grant = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        stall_d    = 1'b0;

        long_ready = (count_q < CNT_W'(DEPTH));
        push       = bus.LongValid && long_ready;
        store      = push && (bus.LongAddr != '0);
        pipe_act   = bus.PipeRegWrite && (bus.PipeWriteAddr != '0);
        not_empty  = (count_q != '0);
        head_valid = valid_q[rd_ptr_q];

        if (stall_q) begin
            pop = not_empty;
        end else if (pipe_act) begin
            pipe_grant = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = bus.PipeWriteAddr;
            wr_data    = bus.PipeWriteData;
        end else begin
            pop = not_empty;
        end

        // A killed head still consumes its slot, it just writes nothing
        if (pop && head_valid) begin
            wr_en   = 1'b1;
            wr_addr = addr_q[rd_ptr_q];
            wr_data = data_q[rd_ptr_q];
        end

        // Younger pipeline write supersedes any queued result for the same register
        if (pipe_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (addr_q[i] == bus.PipeWriteAddr)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = PTR_W'(rd_ptr_q + PTR_W'(1));
        end
        if (store) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = PTR_W'(wr_ptr_q + PTR_W'(1));
        end
        count_d = CNT_W'(count_q + CNT_W'(store) - CNT_W'(pop));

        if (pop || !not_empty) begin
            starve_d = '0;
        end else if (starve_q == STV_W'(STARVE_LIMIT - 2)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = STV_W'(starve_q + STV_W'(1));
        end
    end

    // Decode hazard lookup over stored entries only
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.QueryAddrA)) hit_a = 1'b1;
            if (valid_q[i] && (addr_q[i] == bus.QueryAddrB)) hit_b = 1'b1;
        end
        if (bus.QueryAddrA == '0) hit_a = 1'b0;
        if (bus.QueryAddrB == '0) hit_b = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage needs no reset; valid bits qualify it
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[wr_ptr_q] <= bus.LongAddr;
            data_q[wr_ptr_q] <= bus.LongData;
        end
    end

    assign bus.LongReady       = long_ready;
    assign bus.RegWriteOut     = wr_en && rst_n;
    assign bus.WriteRegAddrOut = wr_addr;
    assign bus.WriteRegData    = wr_data;
    assign bus.StallPipe       = stall_q;
    assign bus.QueryHitA       = hit_a;
    assign bus.QueryHitB       = hit_b;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// by the stimulus and retired by a monitor watching RegWriteOut.
module tb_wb_port_arbiter;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    wb_port_if bus ();

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.PipeRegWrite  = 1'b0;
        bus.PipeWriteAddr = '0;
        bus.PipeWriteData = '0;
        bus.LongValid     = 1'b0;
        bus.LongAddr      = '0;
        bus.LongData      = '0;
        bus.QueryAddrA    = '0;
        bus.QueryAddrB    = '0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        bus.PipeRegWrite  = 1'b1;
        bus.PipeWriteAddr = a;
        bus.PipeWriteData = d;
    endtask

    task automatic long_off();
        bus.LongValid = 1'b0;
        bus.LongAddr  = '0;
        bus.LongData  = '0;
    endtask

    task automatic long_in(input logic [4:0] a, input logic [31:0] d);
        bus.LongValid = 1'b1;
        bus.LongAddr  = a;
        bus.LongData  = d;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.RegWriteOut) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected r%0d=0x%0h at %0t",
                         bus.WriteRegAddrOut, bus.WriteRegData, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.WriteRegAddrOut !== e.a || bus.WriteRegData !== e.d) begin
                    errors++;
                    $display("FAIL write: got r%0d=0x%0h expected r%0d=0x%0h at %0t",
                             bus.WriteRegAddrOut, bus.WriteRegData, e.a, e.d, $time);
                end
            end
        end
    end

    initial begin
        logic [4:0] t3_addr [4];
        checks = 0;
        errors = 0;
        t3_addr[0] = 5'd7;
        t3_addr[1] = 5'd10;
        t3_addr[2] = 5'd11;
        t3_addr[3] = 5'd12;
        rst_n = 1'b0;
        idle();
        pipe(5'd6, 32'h66);
        #12;
        chk("rst_regwrite", 32'(bus.RegWriteOut), 32'd0);
        chk("rst_stall",    32'(bus.StallPipe),   32'd0);
        chk("rst_ready",    32'(bus.LongReady),   32'd1);
        idle();
        rst_n = 1'b1;
        go();

        // Pipe-only write goes straight through
        pipe(5'd5, 32'h11);
        expect_wr(5'd5, 32'h11);
        go();
        idle();
        pipe(5'd0, 32'hDEAD);
        go();
        idle();
        go();

        // Idle drain of two long results
        long_in(5'd7, 32'hAA);
        expect_wr(5'd7, 32'hAA);
        expect_wr(5'd8, 32'hBB);
        #3 chk("t2_ready0", 32'(bus.LongReady), 32'd1);
        go();
        long_in(5'd8, 32'hBB);
        #3 chk("t2_ready1", 32'(bus.LongReady), 32'd1);
        go();
        long_off();
        #3 chk("t2_ready2", 32'(bus.LongReady), 32'd1);
        go();
        idle();
        go();

        // Fill the FIFO while the pipe owns the port
        for (int k = 1; k <= 5; k++) begin
            pipe(5'd20, 32'h300 + 32'(k));
            expect_wr(5'd20, 32'h300 + 32'(k));
            if (k <= 4) long_in(t3_addr[k-1], 32'(k) << 4);
            else long_in(5'd13, 32'hD0);
            bus.QueryAddrA = 5'd7;
            bus.QueryAddrB = 5'd13;
            #3;
            chk("t3_ready", 32'(bus.LongReady), (k < 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                chk("t3_hit_a", 32'(bus.QueryHitA), 32'd1);
                chk("t3_hit_b", 32'(bus.QueryHitB), 32'd0);
            end
            go();
        end
        idle();
        for (int k = 0; k < 4; k++) expect_wr(t3_addr[k], 32'(k + 1) << 4);
        repeat (4) go();
        bus.QueryAddrA = 5'd7;
        #3 chk("t3_hit_after", 32'(bus.QueryHitA), 32'd0);
        go();
        idle();

        // Starvation stall steals one pipeline slot
        for (int k = 0; k <= 9; k++) begin
            pipe(5'd1, 32'h100 + 32'(k));
            if (k == 0) long_in(5'd9, 32'h55);
            else long_off();
            if (k == 8) expect_wr(5'd9, 32'h55);
            else expect_wr(5'd1, 32'h100 + 32'(k));
            #3 chk("t4_stall", 32'(bus.StallPipe), (k == 8) ? 32'd1 : 32'd0);
            go();
        end
        idle();
        go();

        // WAW kill of a queued result
        pipe(5'd2, 32'h22);
        long_in(5'd3, 32'h33);
        expect_wr(5'd2, 32'h22);
        go();
        long_off();
        pipe(5'd3, 32'h44);
        bus.QueryAddrA = 5'd3;
        expect_wr(5'd3, 32'h44);
        #3 chk("t5_hit_before", 32'(bus.QueryHitA), 32'd1);
        go();
        idle();
        bus.QueryAddrA = 5'd3;
        #3 chk("t5_hit_after", 32'(bus.QueryHitA), 32'd0);
        go();
        go();

        // Reset with three entries queued
        for (int k = 0; k < 4; k++) begin
            pipe(5'd4, 32'h400 + 32'(k));
            expect_wr(5'd4, 32'h400 + 32'(k));
            if (k < 3) long_in(5'(14 + k), 32'h1400 + 32'(k));
            else long_off();
            bus.QueryAddrA = 5'd14;
            if (k == 3) #3 chk("t6_hit_pre", 32'(bus.QueryHitA), 32'd1);
            go();
        end
        idle();
        bus.QueryAddrA = 5'd14;
        bus.QueryAddrB = 5'd16;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_regwrite", 32'(bus.RegWriteOut), 32'd0);
        chk("t6_rst_stall",    32'(bus.StallPipe),   32'd0);
        chk("t6_rst_hit_a",    32'(bus.QueryHitA),   32'd0);
        chk("t6_rst_hit_b",    32'(bus.QueryHitB),   32'd0);
        chk("t6_rst_ready",    32'(bus.LongReady),   32'd1);
        #1 rst_n = 1'b1;
        go();
        repeat (10) go();
        chk("t6_hit_post", 32'(bus.QueryHitA), 32'd0);

        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
